// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares a 16x8 scratch memory between a program loader (port 0) and a CPU
// datapath (port 1). One transaction is in flight at a time. Every output is
// driven straight from a register.
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN  defined     -> port 0 always wins contention
//                          not defined -> round-robin on last_grant (default)
//
// Port names (CLK, RESET_N, r0_*, r1_*, mem_*, busy) are fixed by the
// surrounding system, so they carry no _i/_o suffixes.
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    // port 0: program loader
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    // port 1: CPU datapath
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    // memory side
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_oe,
    output logic              mem_we,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        ACK   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;      // 0 = port 0, 1 = port 1
    logic                we_q, we_d;            // latched direction of the granted request
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;   // doubles as the latched address
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d; // doubles as the latched write data
    logic                mem_oe_q, mem_oe_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_load_q, mem_load_d;
    logic                r0_ack_q, r0_ack_d;
    logic                r1_ack_q, r1_ack_d;
    logic [DATA_W-1:0]   r0_rdata_q, r0_rdata_d;
    logic [DATA_W-1:0]   r1_rdata_q, r1_rdata_d;
    logic                busy_q, busy_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic                last_grant_q, last_grant_d;
`endif

    // Grant candidate from the raw request lines; only used while IDLE.
    logic                gnt_valid;
    logic                gnt_port;
    logic                gnt_we;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_wdata;

    // Pick the winning port and mux its request fields.
    always_comb begin
        gnt_valid = r0_req | r1_req;
`ifdef MEM_ARB_FIXED_PRIO_EN
        // Loader always wins; port 1 only gets in when r0_req is low.
        gnt_port  = ~r0_req;
`else
        // On contention, serve the port that did not win last time.
        if (r0_req && r1_req) begin
            gnt_port = ~last_grant_q;
        end else begin
            gnt_port = r1_req;
        end
`endif
        gnt_we    = gnt_port ? r1_we    : r0_we;
        gnt_addr  = gnt_port ? r1_addr  : r0_addr;
        gnt_wdata = gnt_port ? r1_wdata : r0_wdata;
    end

    // Next-state and registered-output logic for the sequencing FSM.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case
        // leaves a variable unassigned and no latch can be inferred.
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        r0_rdata_d   = r0_rdata_q;
        r1_rdata_d   = r1_rdata_q;
        mem_oe_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_load_d   = 1'b0;
        r0_ack_d     = 1'b0;
        r1_ack_d     = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    // Requester fields are captured here and nowhere else.
                    owner_d    = gnt_port;
                    we_d       = gnt_we;
                    mem_addr_d = gnt_addr;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_grant_d = gnt_port;
`endif
                    // Strobes are set up now so they are high during ISSUE.
                    if (gnt_we) begin
                        mem_wdata_d = gnt_wdata;
                        mem_load_d  = ~gnt_port;
                        mem_we_d    = gnt_port;
                    end else begin
                        mem_oe_d    = 1'b1;
                    end
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (we_q) begin
                    // Write is complete once strobed; acknowledge next cycle.
                    r0_ack_d = ~owner_q;
                    r1_ack_d = owner_q;
                    state_d  = ACK;
                end else begin
                    state_d  = CAPT;
                end
            end

            CAPT: begin
                // Memory output became valid on the edge that ended ISSUE.
                if (owner_q) begin
                    r1_rdata_d = mem_rdata;
                end else begin
                    r0_rdata_d = mem_rdata;
                end
                r0_ack_d = ~owner_q;
                r1_ack_d = owner_q;
                state_d  = ACK;
            end

            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; everything clears asynchronously on reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_oe_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_load_q   <= 1'b0;
            r0_ack_q     <= 1'b0;
            r1_ack_q     <= 1'b0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
            busy_q       <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            // Port 0 wins the first contention after reset.
            last_grant_q <= 1'b1;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_oe_q     <= mem_oe_d;
            mem_we_q     <= mem_we_d;
            mem_load_q   <= mem_load_d;
            r0_ack_q     <= r0_ack_d;
            r1_ack_q     <= r1_ack_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
            busy_q       <= busy_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_oe    = mem_oe_q;
    assign mem_we    = mem_we_q;
    assign mem_load  = mem_load_q;
    assign r0_ack    = r0_ack_q;
    assign r1_ack    = r1_ack_q;
    assign r0_rdata  = r0_rdata_q;
    assign r1_rdata  = r1_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural 16x8 memory. Requests
// push their expected read data into per-port queues and the expected grant
// order into an owner queue; a monitor pops and compares on every ack.
module tb_mem_arbiter;

    logic       CLK;
    logic       RESET_N;
    logic       r0_req, r0_we, r0_ack;
    logic [3:0] r0_addr;
    logic [7:0] r0_wdata, r0_rdata;
    logic       r1_req, r1_we, r1_ack;
    logic [3:0] r1_addr;
    logic [7:0] r1_wdata, r1_rdata;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       mem_oe, mem_we, mem_load, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb0[$];
    logic [7:0] sb1[$];
    bit         exp_owner[$];
    logic [7:0] held [2];

    logic [7:0] mem [16];

    mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_ack    (r0_ack),
        .r0_rdata  (r0_rdata),
        .r1_req    (r1_req),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_ack    (r1_ack),
        .r1_rdata  (r1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .mem_load  (mem_load),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural scratch memory: synchronous write, registered read.
    always @(posedge CLK) begin
        if (mem_we || mem_load) mem[mem_addr] <= mem_wdata;
        if (mem_oe) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit port, input bit req, input bit we,
                         input logic [3:0] addr, input logic [7:0] wdata);
        if (port) begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
        end else begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
        end
    endtask

    task automatic set_req(input bit port, input bit v);
        if (port) r1_req = v;
        else      r0_req = v;
    endtask

    // One transaction. Called #1 after a rising edge. With timed=1 the FSM
    // must be idle, so the next edge is the grant edge; strobes, latency and
    // grant-time sampling are checked. hold=1 leaves req high after the ack.
    task automatic txn(input bit port, input bit we, input logic [3:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp_rd,
                       input bit timed, input bit hold);
        int  n;
        bit  seen;
        logic [7:0] e;
        if (we) begin
            e = held[port];
        end else begin
            e = exp_rd;
            held[port] = exp_rd;
        end
        if (port) sb1.push_back(e);
        else      sb0.push_back(e);
        drive(port, 1'b1, we, addr, wdata);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            n++;
            @(posedge CLK);
            @(negedge CLK);
            if (timed && n == 1) begin
                if (we) begin
                    check("issue_strobes", {busy, mem_oe, mem_we, mem_load, r0_ack, r1_ack},
                          {1'b1, 1'b0, port, ~port, 2'b00});
                    check("issue_wdata", mem_wdata, wdata);
                end else begin
                    check("issue_strobes", {busy, mem_oe, mem_we, mem_load, r0_ack, r1_ack},
                          {1'b1, 1'b1, 1'b0, 1'b0, 2'b00});
                end
                check("issue_addr", mem_addr, addr);
                // Changes after the grant must be ignored.
                drive(port, 1'b1, we, addr ^ 4'hC, ~wdata);
            end
            if (timed && n == 2 && !we) begin
                check("capt_strobes", {busy, mem_oe, mem_we, mem_load, r0_ack, r1_ack},
                      {1'b1, 5'b0});
                check("capt_addr", mem_addr, addr);
            end
            seen = port ? r1_ack : r0_ack;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: port %0d got no ack within %0d cycles", port, n);
        end else if (timed) begin
            check("ack_latency", n, we ? 2 : 3);
        end
        @(posedge CLK);
        #1;
        if (timed) check("ack_pulse_end", {r0_ack, r1_ack, busy}, 3'b000);
        if (!hold) set_req(port, 1'b0);
    endtask

    // Scoreboard monitor: compares grant order and read data on every ack.
    always @(negedge CLK) begin
        if (RESET_N && (r0_ack || r1_ack)) begin
            check("single_ack", {r0_ack, r1_ack} == 2'b11, 1'b0);
            if (exp_owner.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: r0_ack=%0d r1_ack=%0d", r0_ack, r1_ack);
            end else begin
                check("grant_order", r1_ack, exp_owner.pop_front());
            end
            if (r0_ack) begin
                if (sb0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r0_sb_empty: ack with no expected entry");
                end else check("r0_rdata", r0_rdata, sb0.pop_front());
            end
            if (r1_ack) begin
                if (sb1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r1_sb_empty: ack with no expected entry");
                end else check("r1_rdata", r1_rdata, sb1.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string name);
        check(name, {busy, mem_oe, mem_we, mem_load, r0_ack, r1_ack,
                     mem_addr, mem_wdata, r0_rdata, r1_rdata}, 64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #1 RESET_N = 1'b0;
        #1 check_reset_outputs("reset_pulse_outputs");
        held[0] = 8'h00;
        held[1] = 8'h00;
        @(posedge CLK);
        #1 RESET_N = 1'b1;
    endtask

    initial begin
        bit any_ack;
        RESET_N = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        held[0] = 8'h00;
        held[1] = 8'h00;
        #12;
        check_reset_outputs("reset_outputs");
        @(posedge CLK);
        #1 RESET_N = 1'b1;

        // Preload through the loader port (mem_load path).
        exp_owner.push_back(1'b0); txn(1'b0, 1'b1, 4'h1, 8'h11, 8'h00, 1'b1, 1'b0);
        exp_owner.push_back(1'b0); txn(1'b0, 1'b1, 4'h2, 8'h22, 8'h00, 1'b1, 1'b0);
        exp_owner.push_back(1'b0); txn(1'b0, 1'b1, 4'h5, 8'h55, 8'h00, 1'b1, 1'b0);

        // Simultaneous reads right after reset: port 0 first.
        pulse_reset();
        exp_owner.push_back(1'b0);
        exp_owner.push_back(1'b1);
        fork
            txn(1'b0, 1'b0, 4'h1, 8'h00, 8'h11, 1'b0, 1'b0);
            txn(1'b1, 1'b0, 4'h2, 8'h00, 8'h22, 1'b0, 1'b0);
        join

        // Both ports requesting continuously for four transactions.
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_owner.push_back(1'b0); exp_owner.push_back(1'b0);
        exp_owner.push_back(1'b1); exp_owner.push_back(1'b1);
`else
        exp_owner.push_back(1'b0); exp_owner.push_back(1'b1);
        exp_owner.push_back(1'b0); exp_owner.push_back(1'b1);
`endif
        fork
            begin
                txn(1'b0, 1'b1, 4'h6, 8'h66, 8'h00, 1'b0, 1'b1);
                txn(1'b0, 1'b0, 4'h6, 8'h00, 8'h66, 1'b0, 1'b0);
            end
            begin
                txn(1'b1, 1'b0, 4'h2, 8'h00, 8'h22, 1'b0, 1'b1);
                txn(1'b1, 1'b1, 4'h8, 8'h88, 8'h00, 1'b0, 1'b0);
            end
        join

        // Port 1 write: mem_we path, rdata held.
        exp_owner.push_back(1'b1); txn(1'b1, 1'b1, 4'h3, 8'hA5, 8'h00, 1'b1, 1'b0);
        // Port 0 write then read back at the top address.
        exp_owner.push_back(1'b0); txn(1'b0, 1'b1, 4'hF, 8'h3C, 8'h00, 1'b1, 1'b0);
        exp_owner.push_back(1'b0); txn(1'b0, 1'b0, 4'hF, 8'h00, 8'h3C, 1'b1, 1'b0);
        // Port 1 read of addr 5; the address moves to 9 during ISSUE.
        exp_owner.push_back(1'b1); txn(1'b1, 1'b0, 4'h5, 8'h00, 8'h55, 1'b1, 1'b0);

        // Reset during CAPT of a port 0 read: no ack, everything cleared.
        drive(1'b0, 1'b1, 1'b0, 4'h5, 8'h00);
        @(posedge CLK);           // grant
        @(posedge CLK);           // ISSUE -> CAPT
        #2 RESET_N = 1'b0;
        #1 check_reset_outputs("mid_capt_reset_outputs");
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        held[0] = 8'h00;
        held[1] = 8'h00;
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        any_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (r0_ack || r1_ack) any_ack = 1'b1;
        end
        check("no_ack_after_reset", any_ack, 1'b0);
        @(posedge CLK);
        #1;

        // Contention after the mid-transaction reset: port 0 wins again.
        exp_owner.push_back(1'b0);
        exp_owner.push_back(1'b1);
        fork
            txn(1'b0, 1'b0, 4'hF, 8'h00, 8'h3C, 1'b0, 1'b0);
            txn(1'b1, 1'b0, 4'h3, 8'h00, 8'hA5, 1'b0, 1'b0);
        join

        repeat (3) @(posedge CLK);
        check("scoreboard_drained", sb0.size() + sb1.size() + exp_owner.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the 16x8 scratch memory between two requesters: port 0 (program loader) and port 1 (CPU datapath).
- Sits between both requesters and the memory.
- Drives the memory's address, data-in, OE, WE and load strobes, and returns read data with a registered ack.
- One transaction in flight at a time; round-robin arbitration.

Parameters:
- ADDR_W, 4, memory address width (16 words).
- DATA_W, 8, memory data width.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- r0_req  input  1  port 0 request; held high until r0_ack.
- r0_we  input  1  port 0 direction: 1 = write, 0 = read.
- r0_addr  input  ADDR_W  port 0 address.
- r0_wdata  input  DATA_W  port 0 write data.
- r0_ack  output  1  port 0 completion pulse, one cycle.
- r0_rdata  output  DATA_W  port 0 read data, valid while r0_ack = 1, then held.
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata  same as port 0, for port 1.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_oe  output  1  memory read strobe.
- mem_we  output  1  memory write strobe, used for port 1 writes.
- mem_load  output  1  memory load strobe, used for port 0 writes.
- mem_rdata  input  DATA_W  memory registered output; updates on the edge that samples mem_oe = 1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset (RESET_N = 0, asynchronous):
  - state = IDLE.
  - All strobes, acks and busy = 0.
  - mem_addr, mem_wdata, r0_rdata, r1_rdata = 0.
  - last_grant = 1, so port 0 wins the first contention.
- FSM states: IDLE, ISSUE, CAPT, ACK.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port not equal to last_grant.
  - On grant, latch owner, we, addr and wdata; update last_grant; go to ISSUE.
  - Requester inputs are sampled only at grant; later changes are ignored until the ack.
- ISSUE (one cycle):
  - mem_addr = latched address.
  - Write: mem_wdata = latched data; assert mem_load if owner = 0, mem_we if owner = 1; next state ACK.
  - Read: assert mem_oe; next state CAPT.
  - Exactly one strobe is high; the other two are 0.
- CAPT (reads only):
  - All strobes low; mem_addr held.
  - mem_rdata is registered into the owner's rX_rdata at the end of this cycle.
  - Next state ACK.
- ACK (one cycle):
  - Owner's rX_ack = 1; the other port's ack = 0.
  - Next state IDLE.
  - rX_rdata holds its value until the next read completes on that port; writes do not change rdata.
- Latency, counted from the edge that samples req in IDLE:
  - Write: ack high in the 2nd cycle after that edge.
  - Read: ack high in the 3rd cycle after that edge.
  - Minimum spacing between grants: 3 cycles (write), 4 cycles (read).
- Requester rule: drop req in the cycle after ack. A req still high when the FSM returns to IDLE is treated as a new request.
- Simultaneous requests with both ports requesting continuously: grants alternate 0, 1, 0, 1.
- Address wrap: none. The address is passed through unchanged, full range 0–15.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; strobes drop asynchronously; no ack is issued.
  - A write strobed in ISSUE before reset may have completed; a pending read is discarded.
- busy = 1 in ISSUE, CAPT and ACK.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 (loader) always wins contention; last_grant is unused and port 1 can starve while r0_req is held.
- Not defined: round-robin as described in Behaviour.
- All other timing is identical in both builds.

Test Plan:
- Port 1 write addr 0x3, data 0xA5 -> ISSUE cycle has mem_we = 1, mem_addr = 3, mem_wdata = 0xA5, mem_load = 0; r1_ack pulses 2 cycles after grant.
- Port 0 write addr 0xF, data 0x3C, then port 0 read addr 0xF -> write uses mem_load = 1; read asserts mem_oe for one cycle; r0_ack pulses 3 cycles after grant with r0_rdata = 0x3C.
- Both ports request reads in the same cycle after reset, port 0 addr 1 (holds 0x11), port 1 addr 2 (holds 0x22) -> port 0 served first, r0_rdata = 0x11; then port 1, r1_rdata = 0x22.
  - With MEM_ARB_FIXED_PRIO_EN and r0_req held: port 1 never acked.
- Both ports requesting continuously for 4 transactions -> grant order 0, 1, 0, 1; never two acks in the same cycle.
- Port 1 changes r1_addr from 5 to 9 during ISSUE -> mem_addr stays 5 through CAPT.
- RESET_N pulsed low during CAPT of a read -> no ack; all outputs 0; busy = 0; the next request is serviced normally with port 0 winning contention.
